// File: rtl/hv_encode_buffer.sv
// Hypervector encoder: per-dimension saturating bipolar vote counters, thresholded
// into a DIM-bit snapshot on an item's last beat, then streamed out as OUT_W-bit words.
module hv_encode_buffer #(
  parameter int DIM   = 128,
  parameter int CNT_W = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_v,
  output logic             upd_ready,
  input  logic [DIM-1:0]   upd_a,
  input  logic [DIM-1:0]   upd_b,
  input  logic             upd_b_en,
  input  logic             upd_last,
  input  logic [DIM-1:0]   tie_rand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int NW    = DIM / OUT_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NW - 1);
  localparam logic signed [CNT_W:0] ONE      = (CNT_W + 1)'(1);
  localparam logic signed [CNT_W:0] NEG_ONE  = -(CNT_W + 1)'(1);
  localparam logic signed [CNT_W:0] SAT_MAX  = {2'b00, {(CNT_W - 1){1'b1}}};
  localparam logic signed [CNT_W:0] SAT_MIN  = {2'b11, {(CNT_W - 1){1'b0}}};

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [DIM-1:0]   hold;
  logic [DIM-1:0]   thresh;
  logic             hold_full;
  logic             accept;
  logic             snapshot;

  // The snapshot register is full exactly while a vector is being streamed.
  assign hold_full = (state == STREAM);
  assign out_valid = hold_full;
  assign out_last  = hold_full && (idx == LAST_IDX);
  assign out_data  = hold_full ? hold[int'(idx)*OUT_W +: OUT_W] : '0;

  assign upd_ready = !hold_full || (out_valid && out_ready && out_last);
  assign accept    = upd_v && upd_ready;
  assign snapshot  = accept && upd_last;

  for (genvar g = 0; g < DIM; g++) begin : g_dim
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W:0]   va, vb, sum;
    logic signed [CNT_W-1:0] sat;

    assign va  = upd_a[g] ? ONE : NEG_ONE;
    assign vb  = !upd_b_en ? '0 : (upd_b[g] ? ONE : NEG_ONE);
    assign sum = $signed({cnt[CNT_W-1], cnt}) + va + vb;
    assign sat = (sum > SAT_MAX) ? SAT_MAX[CNT_W-1:0] :
                 (sum < SAT_MIN) ? SAT_MIN[CNT_W-1:0] : sum[CNT_W-1:0];

    // Threshold the post-update value so the last beat's own votes count.
    assign thresh[g] = (sat == '0) ? tie_rand[g] : !sat[CNT_W-1];

    // NOTE: the counter bank is reset explicitly; a reset abandons the item in progress
    // and the next item must start from zero votes.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= upd_last ? '0 : sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (snapshot) begin
      hold <= thresh;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // NOTE: next-state values are defaulted first so no path leaves them unassigned.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (snapshot) begin
          state_n = STREAM;
          idx_n   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            // A last beat landing on the final handshake restarts the stream with no bubble.
            state_n = snapshot ? STREAM : IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hv_encode_buffer.sv
// Scoreboard bench for hv_encode_buffer: a vote-counting model queues expected words,
// an independent monitor pops and compares them on every output handshake.
module tb_hv_encode_buffer;

  localparam int DIM   = 128;
  localparam int CNT_W = 4;
  localparam int OUT_W = 32;
  localparam int NW    = DIM / OUT_W;
  localparam int CMAX  = 2 ** (CNT_W - 1) - 1;
  localparam int CMIN  = -(2 ** (CNT_W - 1));

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } word_t;

  logic             clk;
  logic             rst;
  logic             upd_v;
  logic             upd_ready;
  logic [DIM-1:0]   upd_a;
  logic [DIM-1:0]   upd_b;
  logic             upd_b_en;
  logic             upd_last;
  logic [DIM-1:0]   tie_rand;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  word_t exp_q[$];
  int    model_cnt[DIM];
  int    checks = 0;
  int    errors = 0;

  logic [DIM-1:0] all1;
  logic [DIM-1:0] all0;
  logic [DIM-1:0] tie_a5;

  hv_encode_buffer #(.DIM(DIM), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_v     (upd_v),
    .upd_ready (upd_ready),
    .upd_a     (upd_a),
    .upd_b     (upd_b),
    .upd_b_en  (upd_b_en),
    .upd_last  (upd_last),
    .tie_rand  (tie_rand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DIM-1:0] rand_vec();
    logic [DIM-1:0] v;
    for (int i = 0; i < DIM / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DIM; i++) model_cnt[i] = 0;
  endtask

  // Reference: integer vote tally with clamping; a last beat emits the thresholded vector.
  task automatic model_beat(input logic [DIM-1:0] a, input logic [DIM-1:0] b, input logic ben,
                            input logic last, input logic [DIM-1:0] tie);
    logic [DIM-1:0] vec;
    word_t          w;
    int             s;
    for (int i = 0; i < DIM; i++) begin
      s = model_cnt[i] + (a[i] ? 1 : -1) + (ben ? (b[i] ? 1 : -1) : 0);
      if (s > CMAX) s = CMAX;
      if (s < CMIN) s = CMIN;
      model_cnt[i] = s;
    end
    if (last) begin
      for (int i = 0; i < DIM; i++) begin
        vec[i] = (model_cnt[i] > 0) ? 1'b1 : (model_cnt[i] < 0) ? 1'b0 : tie[i];
        model_cnt[i] = 0;
      end
      for (int k = 0; k < NW; k++) begin
        w.data = vec[k*OUT_W +: OUT_W];
        w.last = (k == NW - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  // One clock: drive at edge+1, judge upd_ready at edge+7 (after the monitor popped), step.
  task automatic cycle(input logic v, input logic [DIM-1:0] a, input logic [DIM-1:0] b,
                       input logic ben, input logic last, input logic [DIM-1:0] tie,
                       input logic ordy);
    upd_v     = v;
    upd_a     = a;
    upd_b     = b;
    upd_b_en  = ben;
    upd_last  = last;
    tie_rand  = tie;
    out_ready = ordy;
    #6;
    check("upd_ready", upd_ready, exp_q.size() == 0);
    if (upd_v && upd_ready) model_beat(a, b, ben, last, tie);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, all0, all0, 1'b0, 1'b0, all0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      idle(1'b1);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_upd_ready", upd_ready, 1);
    exp_q.delete();
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : monitor
    logic             stall;
    logic [OUT_W-1:0] sd;
    logic             sl;
    word_t            w;
    stall = 1'b0;
    sd    = '0;
    sl    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, sd);
          check("stall_last", out_last, sl);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected no word", out_data);
          end else begin
            w = exp_q.pop_front();
            check("out_data", out_data, w.data);
            check("out_last", out_last, w.last);
          end
        end
        stall = out_valid && !out_ready;
        sd    = out_data;
        sl    = out_last;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    all1   = '1;
    all0   = '0;
    tie_a5 = {(DIM / 8){8'hA5}};
    clear_model();
    rst       = 1'b0;
    upd_v     = 1'b0;
    upd_a     = '0;
    upd_b     = '0;
    upd_b_en  = 1'b0;
    upd_last  = 1'b0;
    tie_rand  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_upd_ready", upd_ready, 1);
    rst = 1'b1;

    // All-ones vote: four all-ones words starting the cycle after the last beat.
    cycle(1'b1, all1, all1, 1'b1, 1'b1, rand_vec(), 1'b1);
    check("first_word_latency", out_valid, 1);
    repeat (NW) idle(1'b1);
    check("ones_idle_after", out_valid, 0);

    // Cancelling votes fall back to the tie-break bits; a-only votes stay positive.
    cycle(1'b1, all1, all0, 1'b1, 1'b1, tie_a5, 1'b1);
    repeat (NW) idle(1'b1);
    cycle(1'b1, all1, all0, 1'b0, 1'b1, tie_a5, 1'b1);
    repeat (NW) idle(1'b1);

    // Saturation: ten +2 beats clamp at the maximum, four -2 beats end at -1.
    repeat (10) cycle(1'b1, all1, all1, 1'b1, 1'b0, rand_vec(), 1'b1);
    repeat (3)  cycle(1'b1, all0, all0, 1'b1, 1'b0, rand_vec(), 1'b1);
    cycle(1'b1, all0, all0, 1'b1, 1'b1, rand_vec(), 1'b1);
    drain();

    // Backpressure mid-vector with update beats offered during the stall.
    cycle(1'b1, rand_vec(), rand_vec(), 1'b1, 1'b1, rand_vec(), 1'b1);
    repeat (2) idle(1'b1);
    repeat (5) cycle(1'b1, all1, all1, 1'b1, $urandom_range(0, 1), rand_vec(), 1'b0);
    repeat (2) idle(1'b1);
    cycle(1'b1, rand_vec(), rand_vec(), $urandom_range(0, 1), 1'b1, rand_vec(), 1'b1);
    drain();

    // Back-to-back vectors: a last beat on every final-word handshake keeps out_valid high.
    cycle(1'b1, rand_vec(), rand_vec(), 1'b1, 1'b1, rand_vec(), 1'b1);
    for (int k = 0; k < 3 * NW; k++) begin
      cycle((k % NW) == NW - 1, rand_vec(), rand_vec(), 1'b1, 1'b1, rand_vec(), 1'b1);
      check("b2b_valid", out_valid, 1);
    end
    drain();

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 1), rand_vec(), rand_vec(), $urandom_range(0, 1),
            $urandom_range(0, 3) == 0, rand_vec(), $urandom_range(0, 9) < 7);
    end
    drain();

    // Reset at word 2 of a stream abandons it.
    cycle(1'b1, all1, all1, 1'b1, 1'b1, rand_vec(), 1'b1);
    repeat (2) idle(1'b1);
    apply_reset();
    idle(1'b1);
    check("post_reset_valid", out_valid, 0);
    cycle(1'b1, all0, all0, 1'b1, 1'b1, rand_vec(), 1'b1);
    drain();

    // Reset during accumulation: partial +6 tallies must be discarded.
    repeat (3) cycle(1'b1, all1, all1, 1'b1, 1'b0, rand_vec(), 1'b1);
    apply_reset();
    cycle(1'b1, all0, all0, 1'b1, 1'b1, rand_vec(), 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hv_encode_buffer.md
# hv_encode_buffer

Parametrised hypervector encode-and-stream block for the HDC accumulation path. It keeps one signed saturating counter per dimension and accumulates bipolar votes from up to two bound vectors per update. On the final update of an item it thresholds the counters into a DIM-bit encoded hypervector, with random tie-break, and clears them. The encoded vector is then streamed to the DMA side as OUT_W-bit words under a valid/ready handshake.

## Interface
- DIM, 128: hypervector dimension; multiple of OUT_W.
- CNT_W, 8: counter width, two's complement, ≥3.
- OUT_W, 32: stream word width.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- upd_v  in  1  update beat valid.
- upd_ready  out  1  update beat accepted when upd_v && upd_ready.
- upd_a  in  DIM  first bound vector; bit=1 votes +1, bit=0 votes −1.
- upd_b  in  DIM  second bound vector, same encoding.
- upd_b_en  in  1  1: add votes from a and b; 0: add votes from a only.
- upd_last  in  1  beat is the last of the current item.
- tie_rand  in  DIM  tie-break bits, sampled only on an accepted last beat.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_W  stream word.
- out_last  out  1  final word of the hypervector.

## Operation
- NW = DIM/OUT_W words per hypervector.
- Counter update on each accepted beat: cnt[i] += va + vb.
  - va = upd_a[i] ? +1 : −1.
  - vb = upd_b_en ? (upd_b[i] ? +1 : −1) : 0.
- Sum is computed at CNT_W+1 bits and saturated to [−2^(CNT_W−1), 2^(CNT_W−1)−1]. There is no wrap-around.
- Snapshot on an accepted beat with upd_last=1:
  - Thresholding uses the post-update value c.
  - hold[i] = c>0 ? 1 : c<0 ? 0 : tie_rand[i].
  - All counters load 0 in the same cycle, so the next item starts clean.
  - hold_full is set.
- Stream FSM states: IDLE and STREAM.
  - IDLE → STREAM on snapshot; idx=0.
  - In STREAM: out_valid=1, out_data=hold[idx*OUT_W +: OUT_W], out_last=(idx==NW−1).
  - Handshake with idx<NW−1: idx increments.
  - Handshake with idx==NW−1: go to IDLE and clear hold_full, unless a snapshot occurs in the same cycle. In that case stay in STREAM with idx=0 and the new hold contents.
- upd_ready = !hold_full || (out_valid && out_ready && out_last).
  - Accumulation stalls only while a previous vector is still being streamed.
- upd_v while upd_ready=0: the beat is ignored and counters are unchanged. Upstream holds the beat.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_last=0, upd_ready=1.
  - All counters 0, hold 0, idx 0, FSM IDLE.
  - Reset mid-stream abandons the vector; no partial word is emitted after release.
- Last beat accepted at edge N → out_valid=1 with word 0 from edge N+1.
- A hypervector occupies at least NW cycles on the stream.
- out_data and out_last hold stable while out_valid && !out_ready.
- out_valid never drops without a handshake.
- Back-to-back: final-word handshake and new last beat in the same cycle → word 0 of the new vector at the next cycle, no bubble.
- upd_ready is registered-path combinational from hold_full, FSM state and out_ready. There is no path from upd_v.
- Counter-to-hold thresholding completes within the single cycle of the accepted last beat.

## Test plan
- Ones vote, DIM=128, OUT_W=32: single beat, upd_a=upd_b=all-ones, upd_b_en=1, upd_last=1 at edge N → four words 0xFFFFFFFF at N+1..N+4 with out_ready=1; out_last only on the 4th; upd_ready=0 from N+1 until the 4th handshake.
- Tie-break: upd_a=all-ones, upd_b=all-zeros, upd_b_en=1, tie_rand=0xA5A5…A5, last → output words equal 0xA5A5A5A5 ×4. Repeat with upd_b_en=0 → all 0xFFFFFFFF.
- Saturation, CNT_W=4: 10 beats of a=b=ones, then 4 beats of a=b=zeros, last on the 14th → all-zero vector. Counter sequence is 7 then −1; without saturation the value would be 12 and the vector all-ones.
- Backpressure: hold out_ready=0 for 5 cycles mid-vector → out_data/out_last unchanged, upd_ready=0, and upd_v beats during the stall leave counters unchanged.
- Back-to-back: present the next item's last beat exactly on the final-word handshake → upd_ready=1 that cycle, word 0 of the new vector on the next cycle, out_valid continuously 1.
- Async reset: assert rst=0 at word 2 of 4 → out_valid=0 immediately. After release, a single all-zero-vote last beat yields four 0x00000000 words, confirming the counters were cleared.
